// File: rtl/sync_ram.sv
// Single-port RAM with valid/ready requests, a registered read (1-cycle latency, DATA_VALID strobe)
// and a zeroing sweep after reset or CLEAR; REQ_READY stays low while the sweep runs and when CLEAR is high.
module sync_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CLEAR,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  OPCODE,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  DATA_VALID,
  output logic                  BUSY
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_sweep_addr;
  logic [ADDR_WIDTH-1:0] w_next_sweep_addr;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_valid;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_rd_accept;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= ST_SWEEP;
      r_sweep_addr <= '0;
    end else begin
      r_state      <= w_next_state;
      r_sweep_addr <= w_next_sweep_addr;
    end
  end

  // CLEAR wins over a same-cycle request by pulling ready low.
  always_comb begin
    w_next_state      = r_state;
    w_next_sweep_addr = r_sweep_addr;
    w_ready           = 1'b0;
    w_mem_we          = 1'b0;
    w_mem_addr        = ADDRESS;
    w_mem_wdata       = DATA_IN;
    case (r_state)
      ST_SWEEP: begin
        w_mem_we          = ~RST;
        w_mem_addr        = r_sweep_addr;
        w_mem_wdata       = '0;
        w_next_sweep_addr = r_sweep_addr + 1'b1;
        if (r_sweep_addr == LAST_ADDR) begin
          w_next_state      = ST_IDLE;
          w_next_sweep_addr = '0;
        end
      end
      ST_IDLE: begin
        w_ready = ~CLEAR;
        if (CLEAR) begin
          w_next_state      = ST_SWEEP;
          w_next_sweep_addr = '0;
        end else begin
          w_mem_we = REQ_VALID & OPCODE;
        end
      end
      default: begin
        w_next_state      = ST_SWEEP;
        w_next_sweep_addr = '0;
      end
    endcase
  end

  assign w_accept    = REQ_VALID & w_ready;
  assign w_rd_accept = w_accept & ~OPCODE;

  always_ff @(posedge CLK) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  // DATA_OUT only moves on an accepted read; sweeps leave it alone.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= w_rd_accept;
      if (w_rd_accept) begin
        r_data_out <= r_mem[ADDRESS];
      end
    end
  end

  assign REQ_READY  = w_ready;
  assign DATA_OUT   = r_data_out;
  assign DATA_VALID = r_data_valid;
  assign BUSY       = (r_state == ST_SWEEP);

endmodule
